// File: rtl/mul_digit_serial.sv
// ---------------------------------------------------------------------------
// mul_digit_serial
//
// Digit-serial W x W multiplier. Operand B is consumed one D-bit digit per
// BUSY cycle (least significant digit first); each digit's partial product
// A * digit is added into a 2W-bit accumulator at the digit's weight. A
// product therefore takes N = W/D cycles after acceptance. Signed operands
// are handled as magnitudes, with a single two's-complement correction on
// the final accumulator write.
//
// Optional feature (compile-time macro MUL_ACC_EN):
//   Adds port in_acc (2W bits, captured at acceptance). The result becomes
//   product + in_acc modulo 2^(2W), i.e. a multiply-accumulate. Latency and
//   handshakes are the same as for the plain multiplier.
//
// Parameters:
//   W : operand width in bits (multiple of D, at least D)
//   D : digit width in bits consumed per BUSY cycle
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operands on in_a/in_b/in_signed are valid
//   in_ready   : block accepts operands this cycle (0 while rst is high)
//   in_a       : multiplicand, W bits
//   in_b       : multiplier, W bits
//   in_signed  : 1 = two's-complement operands, 0 = unsigned
//   in_acc     : (MUL_ACC_EN only) addend, 2W bits
//   out_valid  : out_p holds a completed product
//   out_ready  : consumer takes the product this cycle
//   out_p      : product (or multiply-accumulate result), 2W bits
// ---------------------------------------------------------------------------
module mul_digit_serial #(
  parameter int W = 16,
  parameter int D = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_signed,
`ifdef MUL_ACC_EN
  input  logic [2*W-1:0] in_acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Datapath registers. The multiplicand is kept pre-shifted to the weight
  // of the current digit, and the multiplier is shifted right so the digit
  // being processed always sits in the low D bits. This replaces a
  // variable barrel shift by k*D with two fixed shifts per cycle.
  logic [PW-1:0] a_sh;
  logic [W-1:0]  b_sh;
  logic          neg;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
`ifdef MUL_ACC_EN
  logic [PW-1:0] addend;
`endif

  // Combinational helpers
  logic          accept;
  logic          last_digit;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [D-1:0]  digit;
  logic [PW-1:0] partial;
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] signed_sum;
  logic [PW-1:0] result;

  // -------------------------------------------------------------------------
  // Handshake outputs
  // -------------------------------------------------------------------------
  // in_ready includes the DONE & out_ready term so a new operation can be
  // accepted in the same cycle the previous product is taken; this is a
  // combinational path from out_ready to in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
    end
  end

  assign accept     = in_valid && in_ready;
  assign last_digit = (cnt == CW'(N - 1));

  // -------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // -------------------------------------------------------------------------
  // The most negative value maps to itself, which read as unsigned is the
  // correct magnitude (e.g. 0x8000 -> 0x8000 for W = 16).
  assign mag_a = (in_signed && in_a[W-1]) ? (~in_a + W'(1)) : in_a;
  assign mag_b = (in_signed && in_b[W-1]) ? (~in_b + W'(1)) : in_b;

  // -------------------------------------------------------------------------
  // Per-digit arithmetic (all modulo 2^(2W))
  // -------------------------------------------------------------------------
  assign digit      = b_sh[D-1:0];
  assign partial    = a_sh * {{(PW-D){1'b0}}, digit};
  assign acc_sum    = acc + partial;
  assign signed_sum = neg ? (~acc_sum + PW'(1)) : acc_sum;

`ifdef MUL_ACC_EN
  // The addend is applied after sign correction so it adds to the signed
  // product rather than to its magnitude.
  assign result = signed_sum + addend;
`else
  assign result = signed_sum;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for state_next.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // accept implies out_ready here, so the product is handed off in
        // the same cycle the next operation starts.
        if (accept) begin
          state_next = BUSY;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      out_p  <= '0;
`ifdef MUL_ACC_EN
      addend <= '0;
`endif
    end else if (accept) begin
      a_sh   <= {{W{1'b0}}, mag_a};
      b_sh   <= mag_b;
      neg    <= in_signed && (in_a[W-1] ^ in_b[W-1]);
      acc    <= '0;
      cnt    <= '0;
`ifdef MUL_ACC_EN
      addend <= in_acc;
`endif
    end else if (state == BUSY) begin
      acc  <= acc_sum;
      a_sh <= a_sh << D;
      b_sh <= b_sh >> D;
      cnt  <= cnt + CW'(1);
      // out_p is only written on DONE entry, so it holds the last product
      // through the handoff and while the next operation is in progress.
      if (last_digit) begin
        out_p <= result;
      end
    end
  end

endmodule

// File: tb/tb_mul_digit_serial.sv
// ---------------------------------------------------------------------------
// tb_mul_digit_serial
//
// Self-checking bench for mul_digit_serial. Two instances are exercised:
// W=16/D=8 (two digits per operation) and W=32/D=8 (four digits). Expected
// products come from a plain integer reference model (sign-extend, multiply,
// add, truncate to 2W bits). When built with MUL_ACC_EN the in_acc ports are
// connected and the multiply-accumulate vectors are run as well.
// ---------------------------------------------------------------------------
module tb_mul_digit_serial;

  logic clk;
  logic rst;

  // W = 16 instance
  logic        v16, r16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16, acc16;

  // W = 32 instance
  logic        v32, r32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] p32, acc32;

  int n_tests;
  int n_fail;

  mul_digit_serial #(.W(16), .D(8)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v16),
    .in_ready  (r16),
    .in_a      (a16),
    .in_b      (b16),
    .in_signed (s16),
`ifdef MUL_ACC_EN
    .in_acc    (acc16),
`endif
    .out_valid (ov16),
    .out_ready (or16),
    .out_p     (p16)
  );

  mul_digit_serial #(.W(32), .D(8)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v32),
    .in_ready  (r32),
    .in_a      (a32),
    .in_b      (b32),
    .in_signed (s32),
`ifdef MUL_ACC_EN
    .in_acc    (acc32),
`endif
    .out_valid (ov32),
    .out_ready (or32),
    .out_p     (p32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as signed or unsigned w-bit integers,
  // multiply, add the accumulator term, keep the low 2w bits.
  function automatic logic [63:0] ref_mac(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w,
                                          input logic [63:0] acc);
    longint ax;
    longint bx;
    longint p;
    logic [63:0] mask;
    ax = longint'(a);
    bx = longint'(b);
    if (s && a[w-1]) ax = ax - (longint'(1) << w);
    if (s && b[w-1]) bx = bx - (longint'(1) << w);
    p = ax * bx + longint'(acc);
    mask = (w >= 32) ? '1 : ((64'(1) << (2 * w)) - 64'(1));
    return 64'(p) & mask;
  endfunction

  // Runs one operation on the W=16 instance. Returns with the product in p
  // and the acceptance-to-out_valid latency in lat. With hold set, out_ready
  // stays low and the DUT is left in DONE; otherwise the product is taken.
  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input bit hold, output logic [31:0] p, output int lat);
    int guard;
    @(negedge clk);
    v16 = 1'b1; a16 = a; b16 = b; s16 = s; or16 = !hold;
    #1;
    guard = 0;
    while (r16 !== 1'b1 && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    @(negedge clk);
    // Inputs are junk from here on; the DUT must ignore them.
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    p = p16;
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] p, output int lat);
    int guard;
    @(negedge clk);
    v32 = 1'b1; a32 = a; b32 = b; s32 = s; or32 = 1'b1;
    #1;
    guard = 0;
    while (r32 !== 1'b1 && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
    lat = 0;
    while (ov32 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    p = p32;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v16 = 1'b1; or16 = 1'b1; v32 = 1'b1; or32 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if (r16 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready16: got %b want 0", r16); end
    n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16: got %b want 0", ov16); end
    n_tests++; if (p16 !== 32'h0) begin n_fail++; $display("FAIL reset_out_p16: got %h want 0", p16); end
    n_tests++; if (r32 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready32: got %b want 0", r32); end
    n_tests++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32: got %b want 0", ov32); end
    n_tests++; if (p32 !== 64'h0) begin n_fail++; $display("FAIL reset_out_p32: got %h want 0", p32); end
    rst = 1'b0; v16 = 1'b0; v32 = 1'b0;
    #1;
    n_tests++; if (r16 !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready16: got %b want 1", r16); end
  endtask

  task automatic test_vectors16();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic        ts [3];
    logic [31:0] te [3];
    logic [31:0] p;
    int lat;
    ta = '{16'hFFFF, 16'hFFFF, 16'h8000};
    tb = '{16'hFFFF, 16'h0002, 16'h8000};
    ts = '{1'b0, 1'b1, 1'b1};
    te = '{32'hFFFE0001, 32'hFFFFFFFE, 32'h40000000};
    acc16 = '0;
    for (int i = 0; i < 3; i++) begin
      do_op16(ta[i], tb[i], ts[i], 1'b0, p, lat);
      n_tests++; if (p !== te[i]) begin n_fail++; $display("FAIL vec16_%0d: got %h want %h", i, p, te[i]); end
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL vec16_lat_%0d: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_random16();
    logic [15:0] corner [4];
    logic [15:0] a, b;
    logic        s;
    logic [31:0] exp_p, p;
    int lat;
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      s = 1'($urandom);
`ifdef MUL_ACC_EN
      acc16 = $urandom;
`endif
      exp_p = 32'(ref_mac({16'h0, a}, {16'h0, b}, s, 16, {32'h0, acc16}));
      do_op16(a, b, s, 1'b0, p, lat);
      n_tests++; if (p !== exp_p) begin n_fail++; $display("FAIL rand16_%0d a=%h b=%h s=%b: got %h want %h", i, a, b, s, p, exp_p); end
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL rand16_lat_%0d: got %0d want 2", i, lat); end
      // After handoff: IDLE, product retained.
      n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL rand16_drop_%0d: out_valid got %b want 0", i, ov16); end
      n_tests++; if (p16 !== exp_p) begin n_fail++; $display("FAIL rand16_hold_%0d: out_p got %h want %h", i, p16, exp_p); end
    end
    acc16 = '0;
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    logic [31:0] exp_p, p;
    int lat;
    a = 16'($urandom); b = 16'($urandom);
    acc16 = '0;
    exp_p = 32'(ref_mac({16'h0, a}, {16'h0, b}, 1'b0, 16, 64'h0));
    do_op16(a, b, 1'b0, 1'b1, p, lat);
    n_tests++; if (p !== exp_p) begin n_fail++; $display("FAIL bp_first: got %h want %h", p, exp_p); end
    v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk); #1;
      n_tests++; if (ov16 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b want 1", i, ov16); end
      n_tests++; if (p16 !== exp_p) begin n_fail++; $display("FAIL bp_stable_%0d: got %h want %h", i, p16, exp_p); end
      n_tests++; if (r16 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, r16); end
    end
    or16 = 1'b1; v16 = 1'b1; a16 = 16'd3; b16 = 16'd5; s16 = 1'b0;
    #1;
    n_tests++; if (r16 !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_ready: got %b want 1", r16); end
    @(posedge clk); @(negedge clk);
    v16 = 1'b0;
    n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_drop: got %b want 0", ov16); end
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL bp_lat: got %0d want 2", lat); end
    n_tests++; if (p16 !== 32'h0000000F) begin n_fail++; $display("FAIL bp_second: got %h want 0000000f", p16); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] exp_p;
    int last_t, cyc, got;
    bit acc_now;
    last_t = -1; cyc = 0; got = 0;
    @(negedge clk);
    or16 = 1'b1; v16 = 1'b1;
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
    while (got < 8 && cyc < 200) begin
      #1;
      if (ov16 === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: unexpected product %h", p16);
        end else begin
          exp_p = q.pop_front();
          if (p16 !== exp_p) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", got, p16, exp_p); end
        end
        if (last_t >= 0) begin
          n_tests++; if (cyc - last_t != 3) begin n_fail++; $display("FAIL b2b_rate_%0d: got %0d cycles want 3", got, cyc - last_t); end
        end
        last_t = cyc;
        got++;
      end
      acc_now = (v16 === 1'b1) && (r16 === 1'b1);
      if (acc_now) q.push_back(32'(ref_mac({16'h0, a16}, {16'h0, b16}, s16, 16, {32'h0, acc16})));
      @(posedge clk); cyc++;
      @(negedge clk);
      if (acc_now) begin
        a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
      end
    end
    n_tests++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
    v16 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [31:0] p;
    int lat, seen;
    @(negedge clk);
    v16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678; s16 = 1'b0; or16 = 1'b1; acc16 = '0;
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (r16 !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ready: got %b want 0", r16); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (r16 !== 1'b1) begin n_fail++; $display("FAIL rst_busy_idle: in_ready got %b want 1", r16); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ov16 === 1'b1) seen++;
      @(negedge clk);
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_busy_no_valid: got %0d pulses want 0", seen); end
    do_op16(16'h1234, 16'h5678, 1'b0, 1'b0, p, lat);
    n_tests++; if (p !== 32'h06260060) begin n_fail++; $display("FAIL rst_rerun: got %h want 06260060", p); end
    // Reset while holding a finished product in DONE.
    do_op16(16'($urandom), 16'($urandom), 1'b0, 1'b1, p, lat);
    n_tests++; if (ov16 !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre: out_valid got %b want 1", ov16); end
    rst = 1'b1;
    #1;
    n_tests++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b want 0", ov16); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; or16 = 1'b1;
    #1;
    n_tests++; if (ov16 !== 1'b0 || r16 !== 1'b1) begin n_fail++; $display("FAIL rst_done_idle: valid %b ready %b want 0 1", ov16, r16); end
  endtask

  task automatic test_w32();
    logic [31:0] a, b;
    logic        s;
    logic [63:0] exp_p, p;
    int lat;
    acc32 = '0;
    do_op32(32'hFFFFFFFF, 32'h00000002, 1'b0, p, lat);
    n_tests++; if (p !== 64'h00000001FFFFFFFE) begin n_fail++; $display("FAIL w32_vec: got %h want 00000001fffffffe", p); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL w32_lat: got %0d want 4", lat); end
    do_op32(32'h80000000, 32'h80000000, 1'b1, p, lat);
    n_tests++; if (p !== 64'h4000000000000000) begin n_fail++; $display("FAIL w32_minneg: got %h want 4000000000000000", p); end
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
`ifdef MUL_ACC_EN
      acc32 = {$urandom, $urandom};
`endif
      exp_p = ref_mac(a, b, s, 32, acc32);
      do_op32(a, b, s, p, lat);
      n_tests++; if (p !== exp_p) begin n_fail++; $display("FAIL w32_rand_%0d a=%h b=%h s=%b: got %h want %h", i, a, b, s, p, exp_p); end
      n_tests++; if (lat != 4) begin n_fail++; $display("FAIL w32_rand_lat_%0d: got %0d want 4", i, lat); end
    end
    acc32 = '0;
  endtask

`ifdef MUL_ACC_EN
  task automatic test_acc();
    logic [31:0] p;
    int lat;
    acc16 = 32'hFFFFFFFF;
    do_op16(16'h0003, 16'h0004, 1'b0, 1'b0, p, lat);
    n_tests++; if (p !== 32'h0000000B) begin n_fail++; $display("FAIL acc_wrap: got %h want 0000000b", p); end
    acc16 = 32'h00000001;
    do_op16(16'hFFFF, 16'h0001, 1'b1, 1'b0, p, lat);
    n_tests++; if (p !== 32'h00000000) begin n_fail++; $display("FAIL acc_signed: got %h want 00000000", p); end
    acc16 = '0;
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; or16 = 1'b1; acc16 = '0;
    v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1; acc32 = '0;
    test_reset();
    test_vectors16();
    test_random16();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_w32();
`ifdef MUL_ACC_EN
    test_acc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
